// File: rtl/riscv_pkg.sv
// riscv_pkg: types and constants shared by the core datapath.
//   reg_size    - architectural register / ALU width
//   alu_op_e    - operation select for the combinational ALU
//   arb_state_e - state encoding for the shared-ALU arbiter
package riscv_pkg;

    localparam int reg_size = 32;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } alu_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_EXEC,
        ARB_RESP
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, purely combinational.
//   req[1:0] - request vector
//   ptr      - preferred requester when both request
//   gnt[1:0] - one-hot grant, zero when nothing requests
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // A lone requester always wins; the pointer only breaks ties.
    assign gnt = (req == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage
// (requester 0) and the branch-compare unit (requester 1).
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - per-requester handshake (ready is one-hot or zero)
//   req_op/is_R/rs1/rs2/imm - per-requester operation and operands
//   alu_*               - registered drive to the ALU, results back from it
//   rsp_valid/rsp_ready - response handshake
//   rsp_id/result/is_equal - owner, result and SUB zero flag of the response
module alu_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN = reg_size
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  alu_op_e         req_op    [2],
    input  logic [1:0]      req_is_R,
    input  logic [XLEN-1:0] req_rs1   [2],
    input  logic [XLEN-1:0] req_rs2   [2],
    input  logic [XLEN-1:0] req_imm   [2],
    output logic            alu_is_R,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [XLEN-1:0] alu_imm32,
    output alu_op_e         alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_is_equal,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_is_equal
);

    arb_state_e state;
    logic       rr_ptr;
    logic [1:0] gnt;
    logic       gnt_idx;

    rr_arbiter2 u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign gnt_idx = gnt[1];

    // Grants are offered only while idle, so a pending response blocks
    // new accepts; held low during reset so nothing is accepted then.
    assign req_ready = (state == ARB_IDLE && !rst) ? gnt : 2'b00;

    // The alu_* outputs are the operand registers themselves, so the ALU
    // only ever sees accepted operations.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            rr_ptr       <= 1'b0;
            alu_op       <= ADD;
            alu_is_R     <= 1'b0;
            alu_rs1      <= '0;
            alu_rs2      <= '0;
            alu_imm32    <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_is_equal <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req_valid) begin
                        alu_op    <= req_op[gnt_idx];
                        alu_is_R  <= req_is_R[gnt_idx];
                        alu_rs1   <= req_rs1[gnt_idx];
                        alu_rs2   <= req_rs2[gnt_idx];
                        alu_imm32 <= req_imm[gnt_idx];
                        rsp_id    <= gnt_idx;
                        rr_ptr    <= ~gnt_idx;
                        state     <= ARB_EXEC;
                    end
                end
                ARB_EXEC: begin
                    rsp_result <= alu_result;
                    // The ALU's equality output is only meaningful for SUB.
                    rsp_is_equal <= (alu_op == SUB) ? alu_is_equal : 1'b0;
                    rsp_valid    <= 1'b1;
                    state        <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. A behavioural ALU
// answers the DUT's ALU port; a transaction-level model predicts grants,
// response timing and response contents.
module tb_alu_arbiter;
    import riscv_pkg::*;

    localparam int XLEN = reg_size;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    alu_op_e         req_op  [2];
    logic [1:0]      req_is_R;
    logic [XLEN-1:0] req_rs1 [2];
    logic [XLEN-1:0] req_rs2 [2];
    logic [XLEN-1:0] req_imm [2];
    logic            alu_is_R;
    logic [XLEN-1:0] alu_rs1, alu_rs2, alu_imm32, alu_result;
    alu_op_e         alu_op;
    logic            alu_is_equal;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_is_equal;
    logic [XLEN-1:0] rsp_result;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_is_R(req_is_R),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .alu_is_R(alu_is_R), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_imm32(alu_imm32), .alu_op(alu_op),
        .alu_result(alu_result), .alu_is_equal(alu_is_equal),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_is_equal(rsp_is_equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU behaviour ----------------
    function automatic logic [XLEN-1:0] alu_ref(alu_op_e op, logic [XLEN-1:0] a,
                                                 logic [XLEN-1:0] b);
        case (op)
            ADD:  return a + b;
            SUB:  return a - b;
            SLL:  return a << b[4:0];
            SLT:  return ($signed(a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
            SLTU: return (a < b) ? XLEN'(1) : XLEN'(0);
            XOR:  return a ^ b;
            SRL:  return a >> b[4:0];
            SRA:  return XLEN'($signed(a) >>> b[4:0]);
            OR:   return a | b;
            AND:  return a & b;
            default: return '0;
        endcase
    endfunction

    // The ALU reports operand equality for every op; the arbiter must mask it.
    logic [XLEN-1:0] alu_b;
    always_comb begin
        alu_b        = alu_is_R ? alu_rs2 : alu_imm32;
        alu_result   = alu_ref(alu_op, alu_rs1, alu_b);
        alu_is_equal = (alu_rs1 == alu_b);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit              m_busy = 0;   // an accepted op whose response is not yet consumed
    int              m_age  = 0;   // cycles since accept
    int              m_pref = 0;   // preferred requester on a tie
    alu_op_e         m_op   = ADD;
    logic            m_isr  = 0;
    logic [XLEN-1:0] m_rs1 = 0, m_rs2 = 0, m_imm = 0;
    logic            m_id = 0, m_eq = 0;
    logic [XLEN-1:0] m_res = 0;

    int         cyc = 0;
    int         acc_cyc = 0;
    logic       prev_rsp_valid = 0;
    logic [1:0] obs_gnt = 0;
    logic       obs_rsp_valid = 0;
    int         grant_log[$];
    int         grant_cyc[$];
    logic [XLEN+1:0] rsp_log[$];  // {id, is_equal, result} of consumed responses

    function automatic logic [1:0] exp_grant(logic [1:0] v, int pref);
        if (v[0] && v[1]) return (pref == 1) ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic cycle();
        logic [1:0] eg;
        bit         exp_rv;
        bit         hs;
        int         g;
        logic [XLEN-1:0] opnd;
        eg = 2'b00;
        hs = 0;
        @(negedge clk);
        obs_gnt       = 2'b00;
        obs_rsp_valid = 1'b0;
        if (!rst) begin
            exp_rv = m_busy && (m_age >= 2);
            if (!m_busy) eg = exp_grant(req_valid, m_pref);
            check("req_ready", req_ready, eg);
            check("rsp_valid", rsp_valid, exp_rv);
            check("alu_drive", {alu_op, alu_is_R, alu_rs1, alu_rs2, alu_imm32},
                  {m_op, m_isr, m_rs1, m_rs2, m_imm});
            if (exp_rv) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_result", rsp_result, m_res);
                check("rsp_is_equal", rsp_is_equal, m_eq);
            end
            if (rsp_valid && !prev_rsp_valid) check("latency", cyc - acc_cyc, 2);
            prev_rsp_valid = rsp_valid;
            obs_gnt        = req_ready;
            obs_rsp_valid  = rsp_valid;
            if (req_ready != 2'b00) begin
                grant_log.push_back(int'(req_ready[1]));
                grant_cyc.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_id, rsp_is_equal, rsp_result});
            hs = exp_rv && rsp_ready;
        end
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_age = 0; m_pref = 0;
            m_op = ADD; m_isr = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
            prev_rsp_valid = 0;
        end else if (eg != 2'b00) begin
            g      = eg[1] ? 1 : 0;
            m_op   = req_op[g];
            m_isr  = req_is_R[g];
            m_rs1  = req_rs1[g];
            m_rs2  = req_rs2[g];
            m_imm  = req_imm[g];
            opnd   = m_isr ? m_rs2 : m_imm;
            m_res  = alu_ref(m_op, m_rs1, opnd);
            m_eq   = (m_op == SUB) && (m_rs1 == opnd);
            m_id   = eg[1];
            m_pref = 1 - g;
            m_busy = 1;
            m_age  = 1;
            acc_cyc = cyc;
        end else if (m_busy) begin
            if (hs) m_busy = 0;
            else m_age++;
        end
        cyc++;
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int g, input alu_op_e op, input logic isr,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] imm);
        req_op[g] = op; req_is_R[g] = isr;
        req_rs1[g] = a; req_rs2[g] = b; req_imm[g] = imm;
    endtask

    task automatic rand_req(input int g);
        logic [XLEN-1:0] a;
        a = $urandom;
        set_req(g, alu_op_e'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), a,
                ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom),
                ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom));
    endtask

    task automatic wait_grant(input int g);
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (obs_gnt[g]) got = 1;
        end
        if (!got) check("grant_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_busy; i++) cycle();
        if (m_busy) check("drain_timeout", 0, 1);
    endtask

    task automatic issue(input int g, input alu_op_e op, input logic isr,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] imm);
        set_req(g, op, isr, a, b, imm);
        req_valid[g] = 1'b1;
        wait_grant(g);
        req_valid[g] = 1'b0;
        drain();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_is_equal, rsp_result}, '0);
        check({tag, "_alu"}, {alu_op, alu_is_R, alu_rs1, alu_rs2, alu_imm32},
              {ADD, 1'b0, {(3*XLEN){1'b0}}});
        check({tag, "_ready"}, req_ready, 2'b00);
    endtask

    logic [XLEN+1:0] r;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1; req_is_R = 2'b00;
        for (int g = 0; g < 2; g++) set_req(g, ADD, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
        do_reset();
        cycle();
        check_reset_vals("reset");

        // Single request: ADD 5 + imm 7 from requester 0.
        rsp_log.delete();
        issue(0, ADD, 1'b0, 32'd5, 32'd0, 32'd7);
        check("single_count", rsp_log.size(), 1);
        if (rsp_log.size() > 0) check("single_rsp", rsp_log[0], {1'b0, 1'b0, 32'd12});

        // Simultaneous requests from reset: requester 0 wins first.
        do_reset();
        rsp_log.delete(); grant_log.delete(); grant_cyc.delete();
        set_req(0, XOR, 1'b1, 32'hF0, 32'h0F, 32'h0);
        set_req(1, SUB, 1'b1, 32'd9, 32'd9, 32'h0);
        req_valid = 2'b11;
        for (int i = 0; i < 20 && grant_log.size() < 2; i++) begin
            cycle();
            if (obs_gnt[0]) req_valid[0] = 1'b0;
            if (obs_gnt[1]) req_valid[1] = 1'b0;
        end
        req_valid = 2'b00;
        drain();
        cycle();
        check("dual_grants", grant_log.size(), 2);
        check("dual_rsps", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            check("dual_rsp0", rsp_log[0], {1'b0, 1'b0, 32'hFF});
            check("dual_rsp1", rsp_log[1], {1'b1, 1'b1, 32'h0});
        end

        // Back-pressure: requester 1 OR, response held for 5 cycles.
        rsp_log.delete();
        rsp_ready = 1'b0;
        set_req(1, OR, 1'b0, 32'hA0, 32'h0, 32'h05);
        req_valid[1] = 1'b1;
        wait_grant(1);
        req_valid[1] = 1'b0;
        set_req(0, ADD, 1'b1, 32'd1, 32'd1, 32'd0);
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10 && !obs_rsp_valid; i++) cycle();
        check("bp_valid_0", obs_rsp_valid, 1'b1);
        for (int i = 1; i < 5; i++) begin
            cycle();
            check("bp_held", {obs_rsp_valid, rsp_result}, {1'b1, 32'hA5});
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_done", rsp_log.size(), 1);
        if (rsp_log.size() > 0) check("bp_rsp", rsp_log[0], {1'b1, 1'b0, 32'hA5});
        wait_grant(0);
        req_valid[0] = 1'b0;
        drain();
        cycle();

        // Flag masking: the ALU's equality must not leak for non-SUB ops.
        rsp_log.delete();
        issue(0, SUB, 1'b1, 32'd3, 32'd3, 32'd0);
        issue(0, AND, 1'b1, 32'hFF, 32'h00, 32'd0);
        issue(1, AND, 1'b0, 32'h5A, 32'h0, 32'h5A);
        check("mask_count", rsp_log.size(), 3);
        if (rsp_log.size() == 3) begin
            check("mask_sub", rsp_log[0], {1'b0, 1'b1, 32'h0});
            check("mask_and0", rsp_log[1], {1'b0, 1'b0, 32'h0});
            check("mask_and_eq", rsp_log[2], {1'b1, 1'b0, 32'h5A});
        end

        // Reset while in ARB_EXEC after a requester-0 grant.
        rsp_log.delete();
        set_req(0, ADD, 1'b0, 32'd100, 32'd0, 32'd23);
        req_valid[0] = 1'b1;
        wait_grant(0);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check_reset_vals("midrst");
        check("midrst_no_rsp", rsp_log.size(), 0);
        grant_log.delete(); grant_cyc.delete();
        set_req(1, SLT, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0);
        req_valid = 2'b11;
        cycle();
        check("midrst_gnt", obs_gnt, 2'b01);
        req_valid = 2'b00;
        drain();
        cycle();

        // Continuous contention for 12 cycles.
        grant_log.delete(); grant_cyc.delete();
        rand_req(0); rand_req(1);
        req_valid = 2'b11;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (obs_gnt[0]) rand_req(0);
            if (obs_gnt[1]) rand_req(1);
        end
        req_valid = 2'b00;
        drain();
        cycle();
        check("cont_count", grant_log.size(), 4);
        for (int i = 1; i < grant_log.size(); i++) begin
            check("cont_alt", grant_log[i], 1 - grant_log[i-1]);
            check("cont_space", grant_cyc[i] - grant_cyc[i-1], 3);
        end

        // Randomized traffic with random back-pressure and early withdrawals.
        for (int c = 0; c < 400; c++) begin
            for (int g = 0; g < 2; g++) begin
                if (obs_gnt[g]) begin
                    rand_req(g);
                    req_valid[g] = 1'($urandom_range(0, 1));
                end else if (!req_valid[g]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rand_req(g);
                        req_valid[g] = 1'b1;
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    req_valid[g] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        drain();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `ALU` between two requesters: requester 0 is the execute stage and requester 1 is the branch-compare unit. It accepts one operation at a time through a valid/ready handshake and picks the winner by round-robin. It drives the ALU from registered operands and returns a registered result tagged with the requester id. It sits between the issue logic and `ALU`; the ALU itself is unchanged.

## Interface
- `XLEN`, default 32: operand and result width; must match `reg_size`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: per-requester operation valid.
- `req_ready` out 2: per-requester accept; one-hot or zero.
- `req_op[2]` in alu_op_e: operation per requester.
- `req_is_R` in 2: register-register form (use Rs2, not imm).
- `req_rs1[2]`, `req_rs2[2]`, `req_imm[2]` in XLEN each: operands per requester.
- `alu_is_R` out 1, `alu_rs1`/`alu_rs2`/`alu_imm32` out XLEN, `alu_op` out alu_op_e: drive the ALU.
- `alu_result` in XLEN, `alu_is_equal` in 1: from the ALU.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: index of the requester that owns the response.
- `rsp_result` out XLEN: ALU result.
- `rsp_is_equal` out 1: zero flag; valid for SUB only.

## Operation
- **States:** ARB_IDLE, ARB_EXEC, ARB_RESP. Reset state is ARB_IDLE.
- **ARB_IDLE:**
  - If any `req_valid` is high, grant one requester. `req_ready[g]` is combinational and high only in ARB_IDLE.
  - On the clock edge, latch the winner's op, is_R, rs1, rs2 and imm into operand registers, set `rsp_id<=g`, set `rr_ptr<=~g`, then go to ARB_EXEC.
  - With no request, stay in ARB_IDLE.
- **Round-robin:**
  - `rr_ptr` names the preferred requester; reset value is 0.
  - If only one requester is valid, it wins regardless of `rr_ptr`.
  - If both are valid, `rr_ptr` wins.
- **ARB_EXEC:**
  - The ALU sees the latched operands.
  - On the edge, capture `rsp_result<=alu_result`.
  - Capture `rsp_is_equal<=(op==SUB)?alu_is_equal:0`. This masks the ALU's stale `is_equal` for non-SUB operations.
  - Go to ARB_RESP.
- **ARB_RESP:**
  - `rsp_valid=1`, with result, flag and id held stable.
  - If `rsp_ready` is high, go to ARB_IDLE; otherwise stay (back-pressure, indefinite).
- **ALU drive:**
  - `alu_*` always reflect the operand registers, including in IDLE, so the ALU inputs never toggle from unaccepted requests.
- **Requester obligations:**
  - A requester keeps `req_valid` and its operands stable until `req_ready`.
  - A requester may drop `req_valid` before grant without penalty.
- **Reset mid-operation:**
  - `rst` in any state forces ARB_IDLE and `rr_ptr=0`, clears all output registers, and discards the in-flight response with no `rsp_valid` pulse.
- **Reset values:**
  - `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_is_equal=0`.
  - `alu_op=ADD`, `alu_is_R=0`, `alu_rs1=alu_rs2=alu_imm32=0`.
- **Width rules:** all arithmetic is done by the ALU, modulo 2^XLEN; this block does no arithmetic.

## Timing
- **Accept:** edge N, where `req_valid&req_ready` are both high in cycle N.
- **ALU evaluation:** cycle N+1.
- **Response:** `rsp_valid` high from cycle N+2.
- **Latency:** accept to `rsp_valid` is 2 cycles.
- **Throughput:** with `rsp_ready` tied high, minimum spacing is 3 cycles per operation, and the next grant occurs in cycle N+3.
- **No overlap:** no new request is accepted while a response is pending.
- **Fairness:** under continuous dual requests, grants alternate 0,1,0,1…

## Structure
- Add `typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_RESP} arb_state_e` to `riscv_pkg`.
  - `alu_op_e` and `reg_size` already live there; reuse them.
- One sub-module, `rr_arbiter2`.
  - Inputs: `req[1:0]`, `ptr`.
  - Output: one-hot `gnt[1:0]`.
  - Purely combinational, reusable for other shared units.
- The FSM, operand registers and response registers live in `alu_arbiter`.

## Test plan
- **Single request:** after reset, req0 ADD rs1=5, imm=7, is_R=0.
  - Expect `req_ready[0]` in the same cycle.
  - Expect `rsp_valid` 2 cycles later with `rsp_result=12` and `rsp_id=0`.
- **Simultaneous requests:** both valid from reset; req0 XOR 0xF0^0x0F (is_R=1), req1 SUB 9-9.
  - Expect the first response id0 with result 0xFF and is_equal=0.
  - Expect the second response id1 with result 0 and is_equal=1.
  - Expect `rr_ptr` to alternate.
- **Back-pressure:** req1 OR 0xA0|0x05; hold `rsp_ready=0` for 5 cycles.
  - Expect `rsp_valid` high with result 0xA5 stable throughout.
  - Expect `req_ready=0` for both requesters.
  - Expect the response to complete on the cycle `rsp_ready` rises.
- **Flag masking:** SUB 3-3 followed by AND 0xFF&0x00.
  - Expect the second response to show result 0 with `rsp_is_equal=0`.
- **Reset mid-operation:** assert `rst` in ARB_EXEC.
  - Expect no `rsp_valid`, all outputs at reset values, and ARB_IDLE.
  - Expect the next dual request to grant requester 0.
- **Continuous contention:** both requesters valid for 12 cycles with `rsp_ready=1`.
  - Expect exactly 4 grants alternating 0,1,0,1, each spaced 3 cycles apart.
